// File: rtl/mmcm_ps_pkg.sv
// rtl/mmcm_ps_pkg.sv - shared state encoding, error codes and widths for the MMCM phase-shift sequencer
package mmcm_ps_pkg;
   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_PHASE_STEPS = 448;
   localparam int CH_W            = $clog2(DEF_NUM_CH);
   localparam int PH_W            = $clog2(DEF_PHASE_STEPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_PULSE,
      S_WAIT,
      S_SETTLE,
      S_FIN
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_UNLOCKED = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_BAD_CMD  = 2'd3;
endpackage

// File: rtl/mmcm_ps_phase_acc.sv
// rtl/mmcm_ps_phase_acc.sv - per-channel modulo up/down phase counter with clear
// Ports: psclk/reset clock and async reset; clr forces 0 (wins); inc/dec step by one
// with wrap at PHASE_STEPS; phase is the current count.
module mmcm_ps_phase_acc
   import mmcm_ps_pkg::*;
#(
   parameter int PHASE_STEPS = DEF_PHASE_STEPS,
   parameter int W           = PH_W
) (
   input  logic         psclk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] phase
);
   logic [W-1:0] phase_q, phase_d;

   always_comb begin
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (inc) begin
         phase_d = (phase_q == W'(PHASE_STEPS - 1)) ? '0 : phase_q + 1'b1;
      end else if (dec) begin
         phase_d = (phase_q == '0) ? W'(PHASE_STEPS - 1) : phase_q - 1'b1;
      end
   end

   always_ff @(posedge psclk or posedge reset) begin
      if (reset) phase_q <= '0;
      else       phase_q <= phase_d;
   end

   assign phase = phase_q;
endmodule

// File: rtl/mmcm_ps_sequencer.sv
// rtl/mmcm_ps_sequencer.sv - multi-channel MMCM fine phase-shift command sequencer
// Ports: cmd_* valid/ready command (relative steps or absolute target) for channel cmd_ch;
// psen/psincdec/psdone/locked per-MMCM phase-shift interface; rd_ch/rd_phase registered
// phase readback; busy/done/err/err_code command status.
module mmcm_ps_sequencer
   import mmcm_ps_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int PHASE_STEPS = DEF_PHASE_STEPS,
   parameter int STEP_W      = 10,
   parameter int TIMEOUT     = 64,
   parameter int SETTLE      = 4
) (
   input  logic                           psclk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [$clog2(NUM_CH)-1:0]      cmd_ch,
   input  logic                           cmd_abs,
   input  logic [STEP_W-1:0]              cmd_steps,
   input  logic [STEP_W-1:0]              cmd_target,
   output logic [NUM_CH-1:0]              psen,
   output logic [NUM_CH-1:0]              psincdec,
   input  logic [NUM_CH-1:0]              psdone,
   input  logic [NUM_CH-1:0]              locked,
   input  logic [$clog2(NUM_CH)-1:0]      rd_ch,
   output logic [$clog2(PHASE_STEPS)-1:0] rd_phase,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [1:0]                     err_code
);
   localparam int CW = $clog2(NUM_CH);
   localparam int PW = $clog2(PHASE_STEPS);
   localparam int TW = $clog2((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 1;

   state_t              state_q, state_d;
   logic [CW-1:0]       ch_q, ch_d;
   logic                abs_q, abs_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [STEP_W-1:0]   target_q, target_d;
   logic [STEP_W-1:0]   n_q, n_d;
   logic                dir_q, dir_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                rdy_q;
   logic [NUM_CH-1:0]   locked_q;
   logic [PW-1:0]       rd_phase_q, rd_phase_d;

   logic [PW-1:0]       phase [NUM_CH];
   logic [NUM_CH-1:0]   ph_inc, ph_dec, ph_clr;
   logic                lock_ch, bad_cmd;
   logic [PW-1:0]       cur_phase;
   int                  diff;

   assign lock_ch   = locked[ch_q];
   assign cur_phase = phase[ch_q];
   assign bad_cmd   = (int'(ch_q) >= NUM_CH) || (abs_q && (int'(target_q) >= PHASE_STEPS));
   // A falling lock on any channel means the MMCM restarts at its reset phase.
   assign ph_clr    = locked_q & ~locked;

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      abs_d      = abs_q;
      steps_d    = steps_q;
      target_d   = target_q;
      n_d        = n_q;
      dir_d      = dir_q;
      timer_d    = timer_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      ph_inc     = '0;
      ph_dec     = '0;
      diff       = 0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               ch_d       = cmd_ch;
               abs_d      = cmd_abs;
               steps_d    = cmd_steps;
               target_d   = cmd_target;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            if (bad_cmd) begin
               err_d      = 1'b1;
               err_code_d = ERR_BAD_CMD;
               state_d    = S_FIN;
            end else if (!lock_ch) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNLOCKED;
               state_d    = S_FIN;
            end else begin
               if (abs_q) begin
                  // Shortest way round the circle; an exact half turn goes up.
                  diff = int'(target_q) - int'(cur_phase);
                  if (diff < 0) diff = diff + PHASE_STEPS;
                  if (diff <= PHASE_STEPS / 2) begin
                     n_d   = STEP_W'(diff);
                     dir_d = 1'b1;
                  end else begin
                     n_d   = STEP_W'(PHASE_STEPS - diff);
                     dir_d = 1'b0;
                  end
               end else begin
                  dir_d = ~steps_q[STEP_W-1];
                  n_d   = steps_q[STEP_W-1] ? (~steps_q + 1'b1) : steps_q;
               end
               state_d = (n_d == '0) ? S_FIN : S_PULSE;
            end
         end
         S_PULSE: begin
            if (!lock_ch) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNLOCKED;
               state_d    = S_FIN;
            end else begin
               timer_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!lock_ch) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNLOCKED;
               state_d    = S_FIN;
            end else if (psdone[ch_q]) begin
               // psdone is checked before the timer so a late-but-arrived step still counts.
               ph_inc[ch_q] = dir_q;
               ph_dec[ch_q] = ~dir_q;
               n_d          = n_q - 1'b1;
               timer_d      = '0;
               state_d      = S_SETTLE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = S_FIN;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (!lock_ch) begin
               err_d      = 1'b1;
               err_code_d = ERR_UNLOCKED;
               state_d    = S_FIN;
            end else if (timer_q == TW'(SETTLE - 1)) begin
               state_d = (n_q == '0) ? S_FIN : S_PULSE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      psen     = '0;
      psincdec = '0;
      // Never pulse an MMCM that has just lost lock.
      if (state_q == S_PULSE) begin
         psen[ch_q]     = lock_ch;
         psincdec[ch_q] = dir_q & lock_ch;
      end
   end

   assign rd_phase_d = phase[rd_ch];

   always_ff @(posedge psclk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         abs_q      <= 1'b0;
         steps_q    <= '0;
         target_q   <= '0;
         n_q        <= '0;
         dir_q      <= 1'b0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         rdy_q      <= 1'b0;
         locked_q   <= '0;
         rd_phase_q <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         abs_q      <= abs_d;
         steps_q    <= steps_d;
         target_q   <= target_d;
         n_q        <= n_d;
         dir_q      <= dir_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         rdy_q      <= 1'b1;
         locked_q   <= locked;
         rd_phase_q <= rd_phase_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      mmcm_ps_phase_acc #(
         .PHASE_STEPS(PHASE_STEPS),
         .W          (PW)
      ) u_acc (
         .psclk(psclk),
         .reset(reset),
         .clr  (ph_clr[g]),
         .inc  (ph_inc[g]),
         .dec  (ph_dec[g]),
         .phase(phase[g])
      );
   end

   assign cmd_ready = rdy_q && (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign rd_phase  = rd_phase_q;
endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// tb/tb_mmcm_ps_sequencer.sv - directed self-checking bench for mmcm_ps_sequencer
module tb_mmcm_ps_sequencer;
   localparam int NUM_CH      = 2;
   localparam int PHASE_STEPS = 448;
   localparam int STEP_W      = 10;
   localparam int TIMEOUT     = 64;
   localparam int SETTLE      = 4;

   logic              psclk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [0:0]        cmd_ch = '0;
   logic              cmd_abs = 1'b0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic [STEP_W-1:0] cmd_target = '0;
   logic [1:0]        psen, psincdec;
   logic [1:0]        psdone = '0;
   logic [1:0]        locked = 2'b11;
   logic [0:0]        rd_ch = '0;
   logic [8:0]        rd_phase;
   logic              busy, done, err;
   logic [1:0]        err_code;

   int vectors = 0;
   int miscompares = 0;
   int psdone_dly [NUM_CH];
   int pulse_cnt [NUM_CH];
   int inc_cnt [NUM_CH];
   int done_cnt = 0;
   int multi_psen = 0;
   bit withhold = 1'b0;
   int b_p0, b_p1, b_i0, b_i1, b_d, cyc;

   mmcm_ps_sequencer #(
      .NUM_CH(NUM_CH), .PHASE_STEPS(PHASE_STEPS), .STEP_W(STEP_W),
      .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
   ) dut (
      .psclk(psclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_abs(cmd_abs), .cmd_steps(cmd_steps), .cmd_target(cmd_target),
      .psen(psen), .psincdec(psincdec), .psdone(psdone), .locked(locked),
      .rd_ch(rd_ch), .rd_phase(rd_phase), .busy(busy), .done(done),
      .err(err), .err_code(err_code)
   );

   always #5 psclk = ~psclk;

   // MMCM model: psdone pulses 8 cycles after each psen unless withheld.
   always @(negedge psclk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         psdone[i] = 1'b0;
         if (reset) begin
            psdone_dly[i] = 0;
         end else begin
            if (psdone_dly[i] > 0) begin
               psdone_dly[i] = psdone_dly[i] - 1;
               if (psdone_dly[i] == 0) psdone[i] = 1'b1;
            end
            if (psen[i]) begin
               pulse_cnt[i] = pulse_cnt[i] + 1;
               if (psincdec[i]) inc_cnt[i] = inc_cnt[i] + 1;
               if (!withhold) psdone_dly[i] = 8;
            end
         end
      end
      if (psen == 2'b11) multi_psen = multi_psen + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_p0 = pulse_cnt[0]; b_p1 = pulse_cnt[1];
      b_i0 = inc_cnt[0];   b_i1 = inc_cnt[1];
      b_d  = done_cnt;
   endtask

   task automatic send(input int ch, input bit ab, input int steps, input int target);
      int k;
      @(negedge psclk);
      cmd_ch     = 1'(ch);
      cmd_abs    = ab;
      cmd_steps  = STEP_W'(steps);
      cmd_target = STEP_W'(target);
      cmd_valid  = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin
         @(negedge psclk);
         k++;
      end
      check("cmd_ready_seen", {31'd0, cmd_ready}, 1);
      @(negedge psclk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 3000) begin
         @(negedge psclk);
         n++;
      end
      check("done_seen", {31'd0, done}, 1);
      @(negedge psclk);
   endtask

   task automatic check_phase(input string tag, input int ch, input int exp);
      rd_ch = 1'(ch);
      @(negedge psclk);
      @(negedge psclk);
      check(tag, {23'd0, rd_phase}, exp);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge psclk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
      check("rst_psen", {30'd0, psen}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_err_code", {30'd0, err_code}, 0);
      reset = 1'b0;
      @(negedge psclk);
      check("rel_cmd_ready", {31'd0, cmd_ready}, 1);
      check_phase("rst_phase0", 0, 0);
      check_phase("rst_phase1", 1, 0);

      // Relative +3 on ch0
      snap();
      send(0, 0, 3, 0);
      check("t1_busy", {31'd0, busy}, 1);
      wait_done(cyc);
      check("t1_pulses", pulse_cnt[0] - b_p0, 3);
      check("t1_inc", inc_cnt[0] - b_i0, 3);
      check("t1_ch1_pulses", pulse_cnt[1] - b_p1, 0);
      check("t1_done_cnt", done_cnt - b_d, 1);
      check("t1_busy_after", {31'd0, busy}, 0);
      check("t1_err", {31'd0, err}, 0);
      check_phase("t1_phase", 0, 3);

      // Relative -2 twice: 3 -> 1 -> 447 (wrap down)
      send(0, 0, -2, 0);
      wait_done(cyc);
      check_phase("t2a_phase", 0, 1);
      snap();
      send(0, 0, -2, 0);
      wait_done(cyc);
      check("t2_pulses", pulse_cnt[0] - b_p0, 2);
      check("t2_inc", inc_cnt[0] - b_i0, 0);
      check_phase("t2_phase", 0, 447);

      // ch1 to 10, then absolute 440: shortest path is 18 decrements
      send(1, 0, 10, 0);
      wait_done(cyc);
      check_phase("t3a_phase", 1, 10);
      snap();
      send(1, 1, 0, 440);
      wait_done(cyc);
      check("t3_pulses", pulse_cnt[1] - b_p1, 18);
      check("t3_inc", inc_cnt[1] - b_i1, 0);
      check("t3_ch0_pulses", pulse_cnt[0] - b_p0, 0);
      check_phase("t3_phase1", 1, 440);
      check_phase("t3_phase0", 0, 447);

      // psdone withheld -> timeout
      withhold = 1'b1;
      snap();
      send(0, 0, 1, 0);
      wait_done(cyc);
      check("t4_timeout_window", {31'd0, (cyc >= TIMEOUT && cyc <= TIMEOUT + 6)}, 1);
      check("t4_pulses", pulse_cnt[0] - b_p0, 1);
      check("t4_err", {31'd0, err}, 1);
      check("t4_err_code", {30'd0, err_code}, 2);
      check_phase("t4_phase", 0, 447);
      withhold = 1'b0;

      // Next command clears err; 447 + 1 wraps to 0
      send(0, 0, 1, 0);
      check("t5_err_cleared", {31'd0, err}, 0);
      wait_done(cyc);
      check("t5_err_code", {30'd0, err_code}, 0);
      check_phase("t5_phase", 0, 0);

      // Absolute target equal to current phase: no pulse, still one done
      snap();
      send(0, 1, 0, 0);
      wait_done(cyc);
      check("t6_pulses", pulse_cnt[0] - b_p0, 0);
      check("t6_done_cnt", done_cnt - b_d, 1);
      check("t6_err", {31'd0, err}, 0);

      // Lock drop mid-sequence: abort, ch0 phase cleared, ch1 untouched
      send(0, 0, 2, 0);
      wait_done(cyc);
      check_phase("t7a_phase", 0, 2);
      snap();
      send(0, 0, 5, 0);
      repeat (30) @(negedge psclk);
      locked = 2'b10;
      wait_done(cyc);
      check("t7_abort_early", {31'd0, (pulse_cnt[0] - b_p0) < 5}, 1);
      check("t7_err", {31'd0, err}, 1);
      check("t7_err_code", {30'd0, err_code}, 1);
      check_phase("t7_phase0", 0, 0);
      check_phase("t7_phase1", 1, 440);

      // Command to unlocked channel
      snap();
      send(0, 0, 1, 0);
      wait_done(cyc);
      check("t8_pulses", pulse_cnt[0] - b_p0, 0);
      check("t8_err_code", {30'd0, err_code}, 1);
      locked = 2'b11;
      repeat (12) @(negedge psclk);

      // Absolute target out of range
      snap();
      send(0, 1, 0, 500);
      wait_done(cyc);
      check("t9_pulses", pulse_cnt[0] - b_p0, 0);
      check("t9_err", {31'd0, err}, 1);
      check("t9_err_code", {30'd0, err_code}, 3);

      // Async reset while waiting for psdone
      snap();
      send(1, 0, 3, 0);
      cyc = 0;
      while (pulse_cnt[1] == b_p1 && cyc < 200) begin
         @(negedge psclk);
         cyc++;
      end
      check("t10_first_pulse", pulse_cnt[1] - b_p1, 1);
      repeat (3) @(negedge psclk);
      reset = 1'b1;
      #1;
      check("t10_rst_psen", {30'd0, psen}, 0);
      check("t10_rst_busy", {31'd0, busy}, 0);
      check("t10_rst_cmd_ready", {31'd0, cmd_ready}, 0);
      repeat (2) @(negedge psclk);
      reset = 1'b0;
      @(negedge psclk);
      check("t10_cmd_ready", {31'd0, cmd_ready}, 1);
      snap();
      repeat (30) @(negedge psclk);
      check("t10_no_psen", pulse_cnt[1] - b_p1, 0);
      check_phase("t10_phase0", 0, 0);
      check_phase("t10_phase1", 1, 0);

      check("psen_onehot", multi_psen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
